// File: rtl/conversor_bin_bcd16_pkg.sv
// Shared definitions for the binary-to-BCD converter: default sizes,
// FSM state encoding and the double-dabble correction constants.
package conversor_bin_bcd16_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_DIGITS = 5;

  // A digit of 5 or more would become 10 or more after the shift, so it
  // is pre-corrected by adding 3.
  localparam logic [3:0] BCD_THRESHOLD = 4'd5;
  localparam logic [3:0] BCD_OFFSET    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FIM   = 2'b10
  } state_t;

endpackage

// File: rtl/conversor_bin_bcd16_ajuste_bcd.sv
// Single-digit add-3 correction used before each double-dabble shift.
// Inputs below 5 pass through. Inputs of 5 or more get +3. A valid scratch
// digit never exceeds 9, so the sum stays within 4 bits.
module ajuste_bcd
  import conversor_bin_bcd16_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  // Conditional +3 on one BCD digit
  always_comb begin
    corrected = digit;
    if (digit >= BCD_THRESHOLD) begin
      corrected = digit + BCD_OFFSET;
    end
  end

endmodule

// File: rtl/conversor_bin_bcd16.sv
// Sequential binary-to-BCD converter (double dabble). A start pulse loads
// the binary value. WIDTH shift iterations follow, then the result is
// published on bcd together with a one-cycle done pulse.
module conversor_bin_bcd16
  import conversor_bin_bcd16_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t                state;
  state_t                next_state;
  logic [WIDTH-1:0]      shift_reg;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   adjusted;
  logic [CW-1:0]         count;

  // One correction unit per scratch digit. The units act on the current
  // scratch value, before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    ajuste_bcd u_ajuste (
      .digit     (scratch[4*g +: 4]),
      .corrected (adjusted[4*g +: 4])
    );
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A start that arrives while the FSM is not in IDLE is
  // ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (count == CW'(1)) next_state = FIM;
      FIM:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: load on start, then correct-and-shift once per cycle in SHIFT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      scratch   <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin;
            scratch   <= '0;
            count     <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          scratch   <= {adjusted[4*DIGITS-2:0], shift_reg[WIDTH-1]};
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          count     <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Output registers. bcd changes only when leaving FIM. busy follows the
  // state being entered, so it falls on the same edge that raises done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd  <= '0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (next_state != IDLE);
      if (state == FIM) begin
        bcd  <= scratch;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conversor_bin_bcd16.sv
// Directed and multiplier-driven checks for conversor_bin_bcd16
module tb_conversor_bin_bcd16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int total;
  int bad;

  conversor_bin_bcd16 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the values differ
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference conversion: decimal digits of v, packed four bits per digit
  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Drives start for one edge (edge 0), starting from a negedge.
  // Afterwards the converter must be busy and done must be low.
  task automatic applyStimulus(input logic [15:0] value, input string tag);
    bin   = value;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " busy after start"}, 32'(busy), 32'd1);
    checkOutput({tag, " done low after start"}, 32'(done), 32'd0);
  endtask

  // Waits (bounded) for done. Then checks latency, result and busy.
  task automatic wait_done(input logic [19:0] expected, input string tag);
    int cycles;
    cycles = 0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " latency"}, 32'(cycles), 32'd17);
    checkOutput({tag, " bcd"}, 32'(bcd), 32'(expected));
    checkOutput({tag, " busy in done cycle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int pulses;
    int done_edge;
    logic [19:0] captured;
    logic [15:0] a;
    logic [15:0] b;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset bcd", 32'(bcd), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed values with hand-computed results
    applyStimulus(16'd0, "zero");
    wait_done(20'h00000, "zero");
    @(negedge clk);
    checkOutput("done one cycle", 32'(done), 32'd0);
    applyStimulus(16'd65025, "max product");
    wait_done(20'h65025, "max product");
    @(negedge clk);
    applyStimulus(16'd255, "255");
    wait_done(20'h00255, "255");
    @(negedge clk);
    applyStimulus(16'd9, "nine");
    wait_done(20'h00009, "nine");
    repeat (5) @(negedge clk);
    checkOutput("bcd holds", 32'(bcd), 32'h00009);
    applyStimulus(16'd65535, "all ones");
    wait_done(20'h65535, "all ones");
    @(negedge clk);

    // A start while busy is ignored, and bin changes after the load have no effect
    applyStimulus(16'd1234, "ignore");
    pulses    = 0;
    done_edge = 0;
    captured  = '0;
    for (int e = 1; e <= 40; e++) begin
      start = (e == 5);
      if (e == 5) bin = 16'd9999;
      if (e == 8) bin = 16'h1111;
      @(negedge clk);
      if (done) begin
        pulses++;
        if (done_edge == 0) begin
          done_edge = e;
          captured  = bcd;
        end
      end
    end
    start = 1'b0;
    checkOutput("ignore pulses", 32'(pulses), 32'd1);
    checkOutput("ignore done edge", 32'(done_edge), 32'd17);
    checkOutput("ignore bcd", 32'(captured), 32'h01234);

    // Asynchronous reset in the middle of a conversion
    applyStimulus(16'd5000, "abort");
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int e = 0; e < 25; e++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("abort no done", 32'(pulses), 32'd0);
    applyStimulus(16'd42, "after abort");
    wait_done(20'h00042, "after abort");
    @(negedge clk);

    // Back-to-back: new start issued in the done cycle
    applyStimulus(16'd100, "b2b first");
    wait_done(20'h00100, "b2b first");
    applyStimulus(16'd65535, "b2b second");
    wait_done(20'h65535, "b2b second");
    @(negedge clk);

    // Products from an 8x8 multiplier model
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 255));
      applyStimulus(a * b, "sweep");
      wait_done(to_bcd(32'(a * b)), "sweep");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
